load_store_unit: RTL and testbench

- Data-memory access engine of the RISC-V pipeline.
- Sits between the EX/MEM boundary and the data RAM port.
- Accepts one load/store per request, checks alignment, and generates the byte-lane write data and byte enables.
- Runs a req/ack handshake with a variable-latency data memory, with a timeout. Returns sign/zero-extended load data and the destination register to the writeback stage, and stalls the pipeline while an access is outstanding.

---
 rtl/load_store_unit.sv | 194 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op at a time from EX/MEM, checks alignment,
// drives a req/ack data-memory port with timeout, and returns extended load data.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_WIDTH      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_is_load,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_store_data,
  input  logic [4:0]            req_rd,
  output logic                  busy,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [31:0]           dmem_wdata,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_ack,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  output logic [4:0]            resp_rd,
  output logic                  misaligned,
  output logic                  bus_error,
  output logic [31:0]           fault_addr
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam bit                 TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = TO_EN ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  state_t                state_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  busy_q, dmem_req_q, dmem_we_q;
  logic [ADDR_WIDTH-1:0] dmem_addr_q;
  logic [3:0]            dmem_be_q;
  logic [31:0]           dmem_wdata_q;
  logic                  resp_valid_q, misaligned_q, bus_error_q;
  logic [31:0]           resp_data_q, fault_addr_q;
  logic [4:0]            resp_rd_q;
  logic                  op_load_q;
  logic [2:0]            f3_q;
  logic [31:0]           addr_q;
  logic [4:0]            rd_q;

  logic        is_load_d, is_store_d, accept_d, misalign_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, load_data_d;
  logic [7:0]  byte_d;
  logic [15:0] half_d;

  // Request decode: alignment check and store lane/byte-enable generation.
  always_comb begin
    is_load_d  = req_is_load;
    is_store_d = req_is_store && !req_is_load;
    accept_d   = req_valid && (is_load_d || is_store_d);
    misalign_d = 1'b0;
    be_d       = 4'b1111;
    wdata_d    = '0;
    case (req_funct3[1:0])
      2'b00:   misalign_d = 1'b0;
      2'b01:   misalign_d = req_addr[0];
      default: misalign_d = (req_addr[1:0] != 2'b00);
    endcase
    if (is_store_d) begin
      case (req_funct3[1:0])
        2'b00: begin
          be_d    = 4'b0001 << req_addr[1:0];
          wdata_d = {4{req_store_data[7:0]}};
        end
        2'b01: begin
          be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{req_store_data[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = req_store_data;
        end
      endcase
    end
  end

  // Load data extraction from the returned word using the latched offset and size.
  always_comb begin
    byte_d = '0;
    case (addr_q[1:0])
      2'd0: byte_d = dmem_rdata[7:0];
      2'd1: byte_d = dmem_rdata[15:8];
      2'd2: byte_d = dmem_rdata[23:16];
      2'd3: byte_d = dmem_rdata[31:24];
      default: byte_d = '0;
    endcase
    half_d = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q)
      3'b000:  load_data_d = {{24{byte_d[7]}}, byte_d};
      3'b100:  load_data_d = {24'b0, byte_d};
      3'b001:  load_data_d = {{16{half_d[15]}}, half_d};
      3'b101:  load_data_d = {16'b0, half_d};
      default: load_data_d = dmem_rdata;
    endcase
  end

  // Access FSM with all outputs registered; fault/response pulses last one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= '0;
      dmem_wdata_q <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
      fault_addr_q <= '0;
      op_load_q    <= 1'b0;
      f3_q         <= '0;
      addr_q       <= '0;
      rd_q         <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            if (misalign_d) begin
              misaligned_q <= 1'b1;
              fault_addr_q <= req_addr;
            end else begin
              state_q      <= S_WAIT;
              cnt_q        <= '0;
              busy_q       <= 1'b1;
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= is_store_d;
              dmem_addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              dmem_be_q    <= be_d;
              dmem_wdata_q <= wdata_d;
              op_load_q    <= is_load_d;
              f3_q         <= req_funct3;
              addr_q       <= req_addr;
              rd_q         <= req_rd;
            end
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_data_q  <= op_load_q ? load_data_d : '0;
            resp_rd_q    <= op_load_q ? rd_q : '0;
          end else if (TO_EN && (cnt_q == CNT_LAST)) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            bus_error_q  <= 1'b1;
            fault_addr_q <= addr_q;
          end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_wdata = dmem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_rd    = resp_rd_q;
  assign misaligned = misaligned_q;
  assign bus_error  = bus_error_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected completions,
// a negedge monitor pops and compares whenever a completion/fault pulse appears.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_is_load, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_store_data;
  logic [4:0]  req_rd;
  logic        busy, dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        resp_valid, misaligned, bus_error;
  logic [31:0] resp_data, fault_addr;
  logic [4:0]  resp_rd;

  load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4), .CNT_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_is_load(req_is_load), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_store_data(req_store_data),
    .req_rd(req_rd), .busy(busy), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_rd(resp_rd), .misaligned(misaligned),
    .bus_error(bus_error), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  // kind: 0 = resp_valid, 1 = misaligned, 2 = bus_error
  typedef struct {
    int          kind;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [31:0] fa;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] data, input logic [4:0] rd,
                      input logic [31:0] fa);
    exp_t e;
    e.kind = kind; e.data = data; e.rd = rd; e.fa = fa;
    exp_q.push_back(e);
  endtask

  // Monitor: any completion or fault pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (resp_valid || misaligned || bus_error)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: rv=%0b mis=%0b be=%0b with empty queue",
                 resp_valid, misaligned, bus_error);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        case (e.kind)
          0: begin
            check("resp_valid", {31'b0, resp_valid}, 32'd1);
            check("resp_data", resp_data, e.data);
            check("resp_rd", {27'b0, resp_rd}, {27'b0, e.rd});
            check("resp_busy", {31'b0, busy}, 32'd0);
          end
          1: begin
            check("misaligned", {31'b0, misaligned}, 32'd1);
            check("mis_fault_addr", fault_addr, e.fa);
          end
          default: begin
            check("bus_error", {31'b0, bus_error}, 32'd1);
            check("be_fault_addr", fault_addr, e.fa);
            check("be_no_resp", {31'b0, resp_valid}, 32'd0);
          end
        endcase
      end
    end
  end

  // Issue one op at the current negedge and act as the memory; ack_at is the
  // 0-based WAIT cycle in which ack is driven (-1 = never).
  task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                       input logic [31:0] rdata, input int ack_at, input bit exp_mis,
                       input logic [31:0] exp_addr, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd, input int exp_req_cycles);
    int  n;
    bit  done;
    req_valid = 1'b1; req_is_load = ld; req_is_store = st; req_funct3 = f3;
    req_addr = addr; req_store_data = sd; req_rd = rd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
    if (exp_mis) begin
      check("mis_no_req", {31'b0, dmem_req}, 32'd0);
      check("mis_no_busy", {31'b0, busy}, 32'd0);
    end else begin
      check("req_asserted", {31'b0, dmem_req}, 32'd1);
      check("busy_asserted", {31'b0, busy}, 32'd1);
      check("dmem_we", {31'b0, dmem_we}, {31'b0, st});
      n = 0;
      done = 0;
      for (int k = 0; k < 12 && !done; k++) begin
        if (!dmem_req) begin
          done = 1;
        end else begin
          n++;
          check("dmem_addr", dmem_addr, exp_addr);
          check("dmem_be", {28'b0, dmem_be}, {28'b0, exp_be});
          check("dmem_wdata", dmem_wdata, exp_wd);
          if (k == ack_at) begin
            dmem_ack = 1'b1;
            dmem_rdata = rdata;
            @(negedge clk);
            dmem_ack = 1'b0;
            dmem_rdata = 32'h0;
            done = 1;
          end else begin
            @(negedge clk);
          end
        end
      end
      check("req_cycles", n, exp_req_cycles);
      check("req_dropped", {31'b0, dmem_req}, 32'd0);
      check("busy_dropped", {31'b0, busy}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
    req_funct3 = '0; req_addr = '0; req_store_data = '0; req_rd = '0;
    dmem_rdata = '0; dmem_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_req", {31'b0, dmem_req}, 32'd0);
    check("rst_outs", {dmem_we, dmem_be, resp_valid, resp_rd, misaligned, bus_error}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_rdata", resp_data, 32'd0);
    check("rst_fault", fault_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // LW, immediate ack
    push(0, 32'hDEADBEEF, 5'd5, 32'h0);
    do_op(1, 0, 3'b010, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0, 0, 32'h100, 4'b1111, 32'h0, 1);
    // LB / LBU / LH / LHU on 0x80FF1234
    push(0, 32'hFFFFFF80, 5'd6, 32'h0);
    do_op(1, 0, 3'b000, 32'h203, 32'h0, 5'd6, 32'h80FF1234, 1, 0, 32'h200, 4'b1111, 32'h0, 2);
    push(0, 32'h00000080, 5'd7, 32'h0);
    do_op(1, 0, 3'b100, 32'h203, 32'h0, 5'd7, 32'h80FF1234, 0, 0, 32'h200, 4'b1111, 32'h0, 1);
    push(0, 32'hFFFF80FF, 5'd8, 32'h0);
    do_op(1, 0, 3'b001, 32'h202, 32'h0, 5'd8, 32'h80FF1234, 2, 0, 32'h200, 4'b1111, 32'h0, 3);
    push(0, 32'h000080FF, 5'd9, 32'h0);
    do_op(1, 0, 3'b101, 32'h202, 32'h0, 5'd9, 32'h80FF1234, 0, 0, 32'h200, 4'b1111, 32'h0, 1);
    // SB / SH: writeback no-op
    push(0, 32'h0, 5'd0, 32'h0);
    do_op(0, 1, 3'b000, 32'h11, 32'h000000AB, 5'd3, 32'h0, 0, 0, 32'h10, 4'b0010, 32'hABABABAB, 1);
    push(0, 32'h0, 5'd0, 32'h0);
    do_op(0, 1, 3'b001, 32'h12, 32'h00001234, 5'd4, 32'h0, 1, 0, 32'h10, 4'b1100, 32'h12341234, 2);
    // Misaligned LW and SH
    push(1, 32'h0, 5'd0, 32'h102);
    do_op(1, 0, 3'b010, 32'h102, 32'h0, 5'd1, 32'h0, 0, 1, 32'h0, 4'b0, 32'h0, 0);
    push(1, 32'h0, 5'd0, 32'h101);
    do_op(0, 1, 3'b001, 32'h101, 32'h5555, 5'd1, 32'h0, 0, 1, 32'h0, 4'b0, 32'h0, 0);
    @(negedge clk);
    // Timeout: no ack, then ack exactly in the last allowed cycle
    push(2, 32'h0, 5'd0, 32'h300);
    do_op(1, 0, 3'b010, 32'h300, 32'h0, 5'd10, 32'h0, -1, 0, 32'h300, 4'b1111, 32'h0, 4);
    push(0, 32'h11223344, 5'd11, 32'h0);
    do_op(1, 0, 3'b010, 32'h304, 32'h0, 5'd11, 32'h11223344, 3, 0, 32'h304, 4'b1111, 32'h0, 4);

    // Reset in the 2nd WAIT cycle of an LW
    req_valid = 1'b1; req_is_load = 1'b1; req_funct3 = 3'b010; req_addr = 32'h400; req_rd = 5'd12;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_is_load = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_wait_req", {31'b0, dmem_req}, 32'd0);
    check("rst_wait_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back SW then LW with immediate acks
    push(0, 32'h0, 5'd0, 32'h0);
    do_op(0, 1, 3'b010, 32'h500, 32'hCAFEF00D, 5'd2, 32'h0, 0, 0, 32'h500, 4'b1111, 32'hCAFEF00D, 1);
    push(0, 32'h0BADF00D, 5'd9, 32'h0);
    do_op(1, 0, 3'b010, 32'h500, 32'h0, 5'd9, 32'h0BADF00D, 0, 0, 32'h500, 4'b1111, 32'h0, 1);

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
